muldiv_unit: RTL and testbench

Iterative multiply/divide unit with HI/LO registers for the MIPS datapath. It is the sequential successor to the combinational ALU control. It decodes R-type `funct` under `alu_op` and runs `mult`/`multu`/`div`/`divu` over several cycles. It also serves `mfhi`/`mflo`/`mthi`/`mtlo` and tells the pipeline to stall while a result is pending.

---
 rtl/muldiv_unit.sv | 156 +++++++++++++++
 tb/tb_muldiv_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with HI/LO registers.
// Decodes R-type mult/multu/div/divu and mfhi/mflo/mthi/mtlo, stalls the
// requester while an iteration is in flight.
// Build option: define MULDIV_SIGNED_EN for two's-complement mult/div;
// without it, mult/div behave exactly like multu/divu.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             valid,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
    state_t state, state_nx;

    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;      // mul: {partial hi, multiplier}; div: {remainder, dividend}
    logic [WIDTH-1:0]   opb;      // multiplicand / divisor magnitude
    logic               is_div, neg_q, neg_r;

    logic req_ok, is_mfhi, is_mthi, is_mflo, is_mtlo, is_mul, is_dv, recognised;
    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, div_part, div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, fix_prod;
    logic [WIDTH-1:0]   fix_quo, fix_rem;

    assign req_ok     = valid && (alu_op == 2'b10);
    assign is_mfhi    = req_ok && (funct == 6'h10);
    assign is_mthi    = req_ok && (funct == 6'h11);
    assign is_mflo    = req_ok && (funct == 6'h12);
    assign is_mtlo    = req_ok && (funct == 6'h13);
    assign is_mul     = req_ok && ((funct == 6'h18) || (funct == 6'h19));
    assign is_dv      = req_ok && ((funct == 6'h1A) || (funct == 6'h1B));
    assign recognised = is_mfhi || is_mthi || is_mflo || is_mtlo || is_mul || is_dv;

    assign busy   = (state != S_IDLE);
    assign stall  = recognised && (state != S_IDLE);
    assign result = is_mfhi ? hi : (is_mflo ? lo : '0);

`ifdef MULDIV_SIGNED_EN
    // Signed ops latch operand magnitudes; the signs drive correction in FIX.
    always_comb begin
        sign_a = req_ok && ((funct == 6'h18) || (funct == 6'h1A)) && rs_data[WIDTH-1];
        sign_b = req_ok && ((funct == 6'h18) || (funct == 6'h1A)) && rt_data[WIDTH-1];
        mag_a  = sign_a ? -rs_data : rs_data;
        mag_b  = sign_b ? -rt_data : rt_data;
    end
`else
    // Unsigned-only build: operands pass straight through.
    always_comb begin
        sign_a = 1'b0;
        sign_b = 1'b0;
        mag_a  = rs_data;
        mag_b  = rt_data;
    end
`endif

    // One shift-add / restoring-divide step, plus the FIX sign correction.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};
        div_part = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff = div_part - {1'b0, opb};
        div_next = (div_part >= {1'b0, opb}) ?
                   {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1} :
                   {acc[2*WIDTH-2:0], 1'b0};
        fix_prod = neg_q ? -acc : acc;
        fix_quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        fix_rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state: accept in IDLE, iterate WIDTH cycles, one FIX cycle.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (is_mul)     state_nx = S_MUL;
                else if (is_dv) state_nx = S_DIV;
            end
            S_MUL:   if (count == LAST) state_nx = S_FIX;
            S_DIV:   if (count == LAST) state_nx = S_FIX;
            S_FIX:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath, HI/LO and the registered done pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hi     <= '0;
            lo     <= '0;
            acc    <= '0;
            opb    <= '0;
            count  <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= (state == S_FIX);
            case (state)
                S_IDLE: begin
                    if (is_mul || is_dv) begin
                        acc    <= {{WIDTH{1'b0}}, mag_a};
                        opb    <= mag_b;
                        count  <= '0;
                        is_div <= is_dv;
                        // Divide by zero keeps the all-ones quotient unsigned.
                        neg_q  <= (sign_a ^ sign_b) && !(is_dv && (rt_data == '0));
                        neg_r  <= sign_a;
                    end
                    if (is_mthi) hi <= rs_data;
                    if (is_mtlo) lo <= rs_data;
                end
                S_MUL: begin
                    acc   <= mul_next;
                    count <= count + CW'(1);
                end
                S_DIV: begin
                    acc   <= div_next;
                    count <= count + CW'(1);
                end
                S_FIX: begin
                    if (is_div) begin
                        lo <= fix_quo;
                        hi <= fix_rem;
                    end else begin
                        hi <= fix_prod[2*WIDTH-1:WIDTH];
                        lo <= fix_prod[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit at WIDTH=32.
// Expected HI/LO are queued at issue and checked by a monitor on done.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rstn;
    logic        valid;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] rs_data, rt_data;
    logic        stall, busy, done;
    logic [31:0] hi, lo, result;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] sb_q[$];

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rstn(rstn), .valid(valid), .alu_op(alu_op), .funct(funct),
        .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .busy(busy),
        .done(done), .hi(hi), .lo(lo), .result(result)
    );

    always #5 clk = ~clk;

    // Reference arithmetic in 64-bit integers; returns {hi, lo}.
    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic   sgn;
`ifdef MULDIV_SIGNED_EN
        sgn = (f == 6'h18) || (f == 6'h1A);
`else
        sgn = 1'b0;
`endif
        sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
        if ((f == 6'h18) || (f == 6'h19)) return 64'(sa * sb);
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {32'(sa % sb), 32'(sa / sb)};
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest queued result.
    always @(negedge clk) begin
        if (done) begin
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_done: got hi=%h lo=%h, required no done", hi, lo);
            end else begin
                logic [63:0] e;
                e = sb_q.pop_front();
                if ({hi, lo} !== e) begin
                    n_fail++;
                    $display("FAIL sb_result: got %h_%h required %h_%h", hi, lo, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        valid = 1'b1; alu_op = 2'b10; funct = f; rs_data = a; rt_data = b;
        if (f inside {6'h18, 6'h19, 6'h1A, 6'h1B}) sb_q.push_back(model(f, a, b));
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0; funct = '0;
    endtask

    // Waits for done; n is the cycle index after the accept edge (34 = latency 33).
    task automatic wait_done(output int n);
        n = 1;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL done_timeout: got no done after %0d cycles, required done", n);
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0; valid = 1'b0; alu_op = 2'b00; funct = '0; rs_data = '0; rt_data = '0;
        repeat (2) @(negedge clk);
        n_tests++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy); end
        n_tests++; if (done !== 1'b0)  begin n_fail++; $display("FAIL rst_done: got %b required 0", done); end
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b required 0", stall); end
        n_tests++; if (hi !== 32'h0)   begin n_fail++; $display("FAIL rst_hi: got %h required 0", hi); end
        n_tests++; if (lo !== 32'h0)   begin n_fail++; $display("FAIL rst_lo: got %h required 0", lo); end
        rstn = 1'b1;
        valid = 1'b1; alu_op = 2'b10; funct = 6'h10;
        #1;
        n_tests++; if (result !== 32'h0) begin n_fail++; $display("FAIL rst_mfhi: got %h required 0", result); end
        n_tests++; if (stall !== 1'b0)   begin n_fail++; $display("FAIL rst_mfhi_stall: got %b required 0", stall); end
        @(negedge clk);
        valid = 1'b0; funct = '0;
    endtask

    task automatic test_mul;
        int busy_cnt, done_n, done_cnt, n;
        valid = 1'b1; alu_op = 2'b10; funct = 6'h19; rs_data = 32'hFFFF_FFFF; rt_data = 32'hFFFF_FFFF;
        sb_q.push_back(model(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
        @(posedge clk);
        busy_cnt = 0; done_n = 0; done_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin valid = 1'b0; funct = '0; end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_n == 0) done_n = k;
            end
        end
        n_tests++; if (busy_cnt !== 33) begin n_fail++; $display("FAIL multu_busy_cycles: got %0d required 33", busy_cnt); end
        n_tests++; if (done_n !== 34)   begin n_fail++; $display("FAIL multu_done_time: got %0d required 34", done_n); end
        n_tests++; if (done_cnt !== 1)  begin n_fail++; $display("FAIL multu_done_pulse: got %0d required 1", done_cnt); end
        n_tests++; if (hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi: got %h required fffffffe", hi); end
        n_tests++; if (lo !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo: got %h required 00000001", lo); end

        issue(6'h18, 32'hFFFF_FFFD, 32'd5);
        wait_done(n);
`ifdef MULDIV_SIGNED_EN
        n_tests++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin n_fail++; $display("FAIL mult_neg3x5: got %h_%h required ffffffff_fffffff1", hi, lo); end
`else
        n_tests++; if ({hi, lo} !== 64'h0000_0004_FFFF_FFF1) begin n_fail++; $display("FAIL mult_neg3x5: got %h_%h required 00000004_fffffff1", hi, lo); end
`endif
        for (int i = 0; i < 4; i++) begin
            issue((i % 2 == 0) ? 6'h19 : 6'h18, $urandom, $urandom);
            wait_done(n);
        end
    endtask

    task automatic test_div;
        int n;
        issue(6'h1B, 32'd100, 32'd7);
        wait_done(n);
        n_tests++; if ({hi, lo} !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL divu_100_7: got %h_%h required 00000002_0000000e", hi, lo); end
        n_tests++; if (n !== 34) begin n_fail++; $display("FAIL divu_latency: got %0d required 34", n); end

        issue(6'h1B, 32'd5, 32'd0);
        wait_done(n);
        n_tests++; if ({hi, lo} !== {32'd5, 32'hFFFF_FFFF}) begin n_fail++; $display("FAIL divu_by_zero: got %h_%h required 00000005_ffffffff", hi, lo); end
        n_tests++; if (n !== 34) begin n_fail++; $display("FAIL divu_zero_latency: got %0d required 34", n); end

        issue(6'h1A, 32'hFFFF_FFF9, 32'd2);
        wait_done(n);
`ifdef MULDIV_SIGNED_EN
        n_tests++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_fail++; $display("FAIL div_neg7_2: got %h_%h required ffffffff_fffffffd", hi, lo); end
`else
        n_tests++; if ({hi, lo} !== 64'h0000_0001_7FFF_FFFC) begin n_fail++; $display("FAIL div_neg7_2: got %h_%h required 00000001_7ffffffc", hi, lo); end
`endif
        issue(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n);
        issue(6'h1A, 32'hFFFF_FFF7, 32'd0);
        wait_done(n);
        for (int i = 0; i < 4; i++) begin
            issue((i % 2 == 0) ? 6'h1B : 6'h1A, $urandom, $urandom_range(1, 40000));
            wait_done(n);
        end
    endtask

    task automatic test_move;
        issue(6'h11, 32'hA5A5_0F0F, 32'h0);
        issue(6'h13, 32'h1234_5678, 32'h0);
        valid = 1'b1; funct = 6'h10;
        #1;
        n_tests++; if (result !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL mthi_mfhi: got %h required a5a50f0f", result); end
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mfhi_idle_stall: got %b required 0", stall); end
        funct = 6'h12;
        #1;
        n_tests++; if (result !== 32'h1234_5678) begin n_fail++; $display("FAIL mtlo_mflo: got %h required 12345678", result); end
        alu_op = 2'b00;
        #1;
        n_tests++; if (result !== 32'h0) begin n_fail++; $display("FAIL mflo_not_rtype: got %h required 0", result); end
        alu_op = 2'b10;
        @(negedge clk);
        valid = 1'b0; funct = '0;
    endtask

    task automatic test_hazard;
        logic [63:0] e;
        int n;
        bit seen;
        e = model(6'h18, 32'h0001_0003, 32'hFFFF_0007);
        valid = 1'b1; alu_op = 2'b10; funct = 6'h18; rs_data = 32'h0001_0003; rt_data = 32'hFFFF_0007;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        funct = 6'h12;
        seen = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            #1;
            if (done) begin
                seen = 1'b1;
                n_tests++; if (stall !== 1'b0)     begin n_fail++; $display("FAIL hz_release_stall: got %b required 0", stall); end
                n_tests++; if (result !== e[31:0]) begin n_fail++; $display("FAIL hz_mflo_result: got %h required %h", result, e[31:0]); end
            end else begin
                n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL hz_stall_cycle%0d: got %b required 1", k, stall); end
                @(negedge clk);
            end
        end
        n_tests++; if (!seen) begin n_fail++; $display("FAIL hz_done_timeout: got no done required done"); end
        @(negedge clk);
        valid = 1'b0; funct = '0;

        issue(6'h19, 32'd7, 32'd9);
        valid = 1'b1; funct = 6'h11; rs_data = 32'hDEAD_BEEF;
        #1;
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL hz_mthi_busy_stall: got %b required 1", stall); end
        funct = 6'h20;
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL hz_unrecognised_stall: got %b required 0", stall); end
        funct = 6'h11;
        wait_done(n);
        @(negedge clk);
        valid = 1'b0; funct = '0;
        n_tests++; if ({hi, lo} !== {32'hDEAD_BEEF, 32'd63}) begin n_fail++; $display("FAIL hz_held_mthi: got %h_%h required deadbeef_0000003f", hi, lo); end
    endtask

    task automatic test_reset_mid_div;
        int n;
        issue(6'h1B, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        #2;
        valid = 1'b1; alu_op = 2'b10; funct = 6'h10;
        rstn = 1'b0;
        sb_q.delete();
        #1;
        n_tests++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL mid_rst_busy: got %b required 0", busy); end
        n_tests++; if (stall !== 1'b0)   begin n_fail++; $display("FAIL mid_rst_stall: got %b required 0", stall); end
        n_tests++; if (done !== 1'b0)    begin n_fail++; $display("FAIL mid_rst_done: got %b required 0", done); end
        n_tests++; if ({hi, lo} !== 64'h0) begin n_fail++; $display("FAIL mid_rst_hilo: got %h_%h required 0", hi, lo); end
        @(negedge clk);
        rstn = 1'b1;
        #1;
        n_tests++; if (result !== 32'h0) begin n_fail++; $display("FAIL post_rst_mfhi: got %h required 0", result); end
        @(negedge clk);
        valid = 1'b0; funct = '0;
        issue(6'h1B, 32'hFFFF_FFFF, 32'h10);
        wait_done(n);
        n_tests++; if ({hi, lo} !== {32'hF, 32'h0FFF_FFFF}) begin n_fail++; $display("FAIL post_rst_divu: got %h_%h required 0000000f_0fffffff", hi, lo); end
        n_tests++; if (n !== 34) begin n_fail++; $display("FAIL post_rst_latency: got %0d required 34", n); end
    endtask

    initial begin
        test_reset;
        test_mul;
        test_div;
        test_move;
        test_hazard;
        test_reset_mid_div;
        repeat (2) @(negedge clk);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
